set_ctrl: RTL

SET_CTRL -- requirements
Module: set_ctrl

---
 rtl/set_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/set_ctrl.sv
// Clock/calendar setting controller: button-driven edit of a shadow date/time with a one-cycle load.
// Optional inactivity timeout is compiled in when SET_TIMEOUT_EN is defined.
module set_ctrl #(
    parameter int TIMEOUT_S = 30,
    parameter int YEAR_MIN  = 2000,
    parameter int YEAR_MAX  = 2099
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic [4:0]  btn,
    input  logic [15:0] cur_year,
    input  logic [3:0]  cur_month,
    input  logic [4:0]  cur_day,
    input  logic [4:0]  cur_hour,
    input  logic [5:0]  cur_minute,
    output logic        edit,
    output logic [2:0]  field,
    output logic        blink,
    output logic        load,
    output logic [15:0] set_year,
    output logic [3:0]  set_month,
    output logic [4:0]  set_day,
    output logic [4:0]  set_hour,
    output logic [5:0]  set_minute
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EDIT,
        ST_COMMIT
    } state_t;

    localparam logic [2:0]  F_YEAR   = 3'd0;
    localparam logic [2:0]  F_MONTH  = 3'd1;
    localparam logic [2:0]  F_DAY    = 3'd2;
    localparam logic [2:0]  F_HOUR   = 3'd3;
    localparam logic [2:0]  F_MINUTE = 3'd4;
    localparam logic [15:0] Y_MIN    = 16'(YEAR_MIN);
    localparam logic [15:0] Y_MAX    = 16'(YEAR_MAX);

    // Button bit positions within {mid,left,right,up,down}
    localparam int B_MID   = 4;
    localparam int B_LEFT  = 3;
    localparam int B_RIGHT = 2;
    localparam int B_UP    = 1;
    localparam int B_DOWN  = 0;

    function automatic logic [4:0] days_in_month(input logic [15:0] y, input logic [3:0] m);
        logic leap;
        leap = (y[1:0] == 2'b00) && (((y % 16'd100) != 16'd0) || ((y % 16'd400) == 16'd0));
        case (m)
            4'd2:                      days_in_month = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   days_in_month = 5'd30;
            default:                   days_in_month = 5'd31;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  field_q, field_d;
    logic        blink_q, blink_d;
    logic [15:0] year_q, year_d;
    logic [3:0]  month_q, month_d;
    logic [4:0]  day_q, day_d;
    logic [4:0]  hour_q, hour_d;
    logic [5:0]  minute_q, minute_d;
    logic [4:0]  btn_q, btn_prev_q;

    logic [4:0]  rise;
    logic        act_mid, act_up, act_down, act_left, act_right;
    logic        field_chg;
    logic [4:0]  dim_cur;
    logic [4:0]  dim_new;

    // Input is registered once, then compared to its previous sample: actions land one cycle after the rise
    assign rise      = btn_q & ~btn_prev_q;
    assign act_mid   = rise[B_MID];
    assign act_up    = rise[B_UP]    & ~rise[B_MID];
    assign act_down  = rise[B_DOWN]  & ~rise[B_MID] & ~rise[B_UP];
    assign act_left  = rise[B_LEFT]  & ~rise[B_MID] & ~rise[B_UP] & ~rise[B_DOWN];
    assign act_right = rise[B_RIGHT] & ~rise[B_MID] & ~rise[B_UP] & ~rise[B_DOWN] & ~rise[B_LEFT];

    assign dim_cur = days_in_month(year_q, month_q);

`ifdef SET_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_S + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        blink_d   = blink_q;
        year_d    = year_q;
        month_d   = month_q;
        day_d     = day_q;
        hour_d    = hour_q;
        minute_d  = minute_q;
        field_chg = 1'b0;
        dim_new   = dim_cur;
`ifdef SET_TIMEOUT_EN
        tmo_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                blink_d = 1'b0;
                if (act_mid) begin
                    state_d  = ST_EDIT;
                    year_d   = cur_year;
                    month_d  = cur_month;
                    day_d    = cur_day;
                    hour_d   = cur_hour;
                    minute_d = cur_minute;
                    field_d  = F_YEAR;
                end
            end
            ST_EDIT: begin
                if (act_mid) begin
                    state_d = ST_COMMIT;
                end else if (act_up || act_down) begin
                    case (field_q)
                        F_YEAR: begin
                            if (act_up) year_d = (year_q >= Y_MAX) ? Y_MIN : year_q + 16'd1;
                            else        year_d = (year_q <= Y_MIN) ? Y_MAX : year_q - 16'd1;
                        end
                        F_MONTH: begin
                            if (act_up) month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
                            else        month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
                        end
                        F_DAY: begin
                            if (act_up) day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
                            else        day_d = (day_q <= 5'd1) ? dim_cur : day_q - 5'd1;
                        end
                        F_HOUR: begin
                            if (act_up) hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
                            else        hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
                        end
                        default: begin
                            if (act_up) minute_d = (minute_q >= 6'd59) ? 6'd0 : minute_q + 6'd1;
                            else        minute_d = (minute_q == 6'd0) ? 6'd59 : minute_q - 6'd1;
                        end
                    endcase
                    // A year or month change may shorten the month below the held day
                    if (field_q == F_YEAR || field_q == F_MONTH) begin
                        dim_new = days_in_month(year_d, month_d);
                        if (day_q > dim_new) day_d = dim_new;
                    end
                end else if (act_left) begin
                    field_d   = (field_q == F_YEAR) ? F_MINUTE : field_q - 3'd1;
                    field_chg = 1'b1;
                end else if (act_right) begin
                    field_d   = (field_q >= F_MINUTE) ? F_YEAR : field_q + 3'd1;
                    field_chg = 1'b1;
                end

                if (field_chg)     blink_d = 1'b0;
                else if (tick_1hz) blink_d = ~blink_q;

`ifdef SET_TIMEOUT_EN
                if (|rise) begin
                    tmo_d = '0;
                end else if (tick_1hz) begin
                    if (tmo_q >= TMO_W'(TIMEOUT_S - 1)) begin
                        state_d = ST_IDLE;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q;
                end
`endif
                if (state_d != ST_EDIT) blink_d = 1'b0;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                blink_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            field_q    <= F_YEAR;
            blink_q    <= 1'b0;
            year_q     <= Y_MIN;
            month_q    <= 4'd1;
            day_q      <= 5'd1;
            hour_q     <= 5'd0;
            minute_q   <= 6'd0;
            btn_q      <= '1;
            btn_prev_q <= '1;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            blink_q    <= blink_d;
            year_q     <= year_d;
            month_q    <= month_d;
            day_q      <= day_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            btn_q      <= btn;
            btn_prev_q <= btn_q;
        end
    end

`ifdef SET_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    assign edit       = (state_q == ST_EDIT);
    assign load       = (state_q == ST_COMMIT);
    assign field      = field_q;
    assign blink      = blink_q;
    assign set_year   = year_q;
    assign set_month  = month_q;
    assign set_day    = day_q;
    assign set_hour   = hour_q;
    assign set_minute = minute_q;

endmodule
